// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration-port initiator.
package fll_cfg_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned ACK_TIMEOUT_DEF  = 256;
  localparam int unsigned LOCK_TIMEOUT_DEF = 65536;
  localparam int unsigned LOCK_SYNC_DEF    = 2;

  localparam logic WRN_WRITE = 1'b1;
  localparam logic WRN_READ  = 1'b0;

  // FLL register map
  localparam logic [ADDR_W-1:0] FLL_ADDR_STATUS = 2'd0;
  localparam logic [ADDR_W-1:0] FLL_ADDR_CFG1   = 2'd1;
  localparam logic [ADDR_W-1:0] FLL_ADDR_CFG2   = 2'd2;
  localparam logic [ADDR_W-1:0] FLL_ADDR_INTEG  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_LOCK_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic              lockwait;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fll_cfg_master_if.sv
// Command/response and FLL-port signals between the SoC side, the initiator and the FLL.
interface fll_cfg_master_if;
  import fll_cfg_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic              cmd_lockwait;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              fll_req;
  logic              fll_wrn;
  logic [ADDR_W-1:0] fll_add;
  logic [DATA_W-1:0] fll_data;
  logic              fll_ack;
  logic [DATA_W-1:0] fll_r_data;

  modport master (
    input  cmd_valid, cmd_we, cmd_lockwait, cmd_addr, cmd_wdata,
    output cmd_ready,
    output resp_valid, resp_rdata, resp_err,
    output fll_req, fll_wrn, fll_add, fll_data,
    input  fll_ack, fll_r_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_lockwait, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  fll_req, fll_wrn, fll_add, fll_data,
    output fll_ack, fll_r_data
  );

endinterface

// File: rtl/fll_lock_sync.sv
// Multi-stage synchroniser bringing the asynchronous FLL lock into the clk_i domain.
module fll_lock_sync
  import fll_cfg_pkg::*;
#(
  parameter int unsigned STAGES = LOCK_SYNC_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/fll_cfg_master.sv
// Turns single-beat register commands into FLL req/ack transactions with ack/lock timeouts
// and returns one response strobe per accepted command.
module fll_cfg_master
  import fll_cfg_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int unsigned LOCK_SYNC    = LOCK_SYNC_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fll_cfg_master_if.master bus,
  input  logic             fll_lock_i,
  output logic             lock_o
);

  // One counter serves both the ack and the lock timeout.
  localparam int unsigned      CNT_W     = $clog2(max_u(ACK_TIMEOUT, LOCK_TIMEOUT));
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              req_q, req_d;
  logic              resp_valid_q, resp_valid_d;

  fll_lock_sync #(
    .STAGES (LOCK_SYNC)
  ) u_lock_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (fll_lock_i),
    .sync_o  (lock_o)
  );

  // Next state, captured command/response and next registered outputs
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          cmd_d = '{we:       bus.cmd_we,
                    lockwait: bus.cmd_lockwait,
                    addr:     bus.cmd_addr,
                    wdata:    bus.cmd_wdata};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack in the timeout cycle still completes the transaction cleanly.
        if (bus.fll_ack) begin
          rdata_d = cmd_q.we ? '0 : bus.fll_r_data;
          err_d   = 1'b0;
          state_d = (cmd_q.we && cmd_q.lockwait) ? ST_LOCK_WAIT : ST_RESP;
        end else if (cnt_q == ACK_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_LOCK_WAIT: begin
        if (lock_o) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    ready_d      = (state_d == ST_IDLE);
    req_d        = (state_d == ST_REQ);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b0;
      req_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      req_q        <= req_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // FLL address/data come straight from the command register, so they hold outside REQ.
  assign bus.cmd_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.fll_req    = req_q;
  assign bus.fll_wrn    = cmd_q.we ? WRN_WRITE : WRN_READ;
  assign bus.fll_add    = cmd_q.addr;
  assign bus.fll_data   = cmd_q.wdata;

endmodule

// File: tb/tb_fll_cfg_master.sv
// Randomised scoreboard bench for fll_cfg_master with a behavioural FLL responder and lock source.
module tb_fll_cfg_master;
  import fll_cfg_pkg::*;

  localparam int ACK_TO  = 16;
  localparam int LOCK_TO = 32;
  localparam int SYNC    = 2;
  localparam int NEVER   = 1000;
  localparam int FAR     = 1000000000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          req_cycles;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic fll_lock_i = 1'b0;
  logic lock_o;

  fll_cfg_master_if bus ();

  fll_cfg_master #(
    .ACK_TIMEOUT  (ACK_TO),
    .LOCK_TIMEOUT (LOCK_TO),
    .LOCK_SYNC    (SYNC)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus),
    .fll_lock_i (fll_lock_i),
    .lock_o     (lock_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t        sb_q[$];
  logic        hist[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lock_rise = FAR;
  int          cur_delay = 0;
  logic        cur_we = 1'b0;
  logic [1:0]  cur_addr = 2'd0;
  logic [31:0] cur_wdata = 32'd0;
  int          resp_cnt = 0;
  int          req_run = 0;
  logic [31:0] mdl      [4] = '{32'h1000_0000, 32'h1000_0001, 32'hDEAD_BEEF, 32'h1000_0003};
  logic [31:0] fll_regs [4] = '{32'h1000_0000, 32'h1000_0001, 32'hDEAD_BEEF, 32'h1000_0003};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FLL responder: acks after cur_delay cycles of req, register file behind it
  assign bus.fll_ack    = bus.fll_req && (resp_cnt >= cur_delay);
  assign bus.fll_r_data = fll_regs[bus.fll_add];

  always @(posedge clk_i) begin
    cyc      <= cyc + 1;
    resp_cnt <= bus.fll_req ? resp_cnt + 1 : 0;
    if (bus.fll_req && bus.fll_ack && bus.fll_wrn == WRN_WRITE)
      fll_regs[bus.fll_add] <= bus.fll_data;
  end

  // Lock source: high from cycle lock_rise onward
  always @(posedge clk_i) begin
    #1;
    fll_lock_i = (cyc >= lock_rise);
  end

  // Monitor: lock delay line, FLL bus contents, and response scoreboard
  always @(negedge clk_i) begin
    if (rst_i) begin
      req_run = 0;
      hist.delete();
      repeat (SYNC) hist.push_back(1'b0);
    end else begin
      check("lock_o", 32'(lock_o), 32'(hist[0]));
      void'(hist.pop_front());
      hist.push_back(fll_lock_i);
      if (bus.fll_req) begin
        req_run++;
        check("fll_wrn", 32'(bus.fll_wrn), 32'(cur_we ? WRN_WRITE : WRN_READ));
        check("fll_add", 32'(bus.fll_add), 32'(cur_addr));
        check("fll_data", bus.fll_data, cur_wdata);
      end
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_err", 32'(bus.resp_err), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
          check("req_high_cycles", 32'(req_run), 32'(e.req_cycles));
        end
        req_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int waited = 0;
    while ((sb_q.size() != 0 || !bus.cmd_ready) && waited < 2000) begin
      @(negedge clk_i);
      waited++;
    end
    if (sb_q.size() != 0 || !bus.cmd_ready)
      check("idle_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  // Issue one command; lmode 0=lock already high, 1=never, 2=rises loff cycles after LOCK_WAIT entry
  task automatic do_tx(input logic we, input logic lw, input logic [1:0] addr,
                       input logic [31:0] wdata, input int delay, input int lmode,
                       input int loff, input bit expect_resp);
    int   k;
    int   t;
    int   j;
    int   waited;
    bit   acked;
    bit   lockw;
    exp_t e;
    acked = (delay + 1 <= ACK_TO);
    k     = acked ? delay + 1 : ACK_TO;
    lockw = we && lw && acked;
    if (lockw) begin
      wait_idle();
      lock_rise = (lmode == 0) ? 0 : FAR;
      repeat (SYNC + 3) @(posedge clk_i);
    end
    @(posedge clk_i);
    #1;
    bus.cmd_valid    = 1'b1;
    bus.cmd_we       = we;
    bus.cmd_lockwait = lw;
    bus.cmd_addr     = addr;
    bus.cmd_wdata    = wdata;
    waited = 0;
    do begin
      @(negedge clk_i);
      waited++;
    end while (!bus.cmd_ready && waited < 500);
    if (!bus.cmd_ready) begin
      check("accept_timeout", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk_i);
      #1;
      bus.cmd_valid = 1'b0;
      return;
    end
    t         = cyc;
    cur_delay = delay;
    cur_we    = we;
    cur_addr  = addr;
    cur_wdata = wdata;
    if (lockw && lmode == 2) lock_rise = t + k + 1 + loff;
    e.req_cycles = k;
    if (!acked) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
      e.cyc   = t + k + 1;
    end else if (lockw) begin
      j = (lmode == 0) ? 1 : (lmode == 1) ? LOCK_TO + 1 : loff + SYNC + 1;
      e.rdata = 32'd0;
      e.err   = (j > LOCK_TO);
      e.cyc   = t + k + 1 + ((j > LOCK_TO) ? LOCK_TO : j);
    end else begin
      e.rdata = we ? 32'd0 : mdl[addr];
      e.err   = 1'b0;
      e.cyc   = t + k + 1;
    end
    if (expect_resp) sb_q.push_back(e);
    if (we && acked) mdl[addr] = wdata;
    @(posedge clk_i);
    #1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_we       = 1'($urandom_range(0, 1));
    bus.cmd_lockwait = 1'($urandom_range(0, 1));
    bus.cmd_addr     = 2'($urandom_range(0, 3));
    bus.cmd_wdata    = $urandom;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int sel;
    bus.cmd_valid    = 1'b0;
    bus.cmd_we       = 1'b0;
    bus.cmd_lockwait = 1'b0;
    bus.cmd_addr     = 2'd0;
    bus.cmd_wdata    = 32'd0;

    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_fll_req", 32'(bus.fll_req), 32'd0);
    check("rst_fll_data", bus.fll_data, 32'd0);
    check("rst_lock_o", 32'(lock_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Directed cases
    do_tx(1'b0, 1'b0, FLL_ADDR_CFG2, 32'h0, 0, 0, 0, 1'b1);
    do_tx(1'b1, 1'b0, FLL_ADDR_CFG1, 32'h0000_1234, 4, 0, 0, 1'b1);
    do_tx(1'b0, 1'b0, FLL_ADDR_CFG1, 32'h0, 2, 0, 0, 1'b1);
    do_tx(1'b1, 1'b1, FLL_ADDR_CFG2, 32'hA5A5_0001, 2, 2, 20, 1'b1);
    do_tx(1'b0, 1'b0, FLL_ADDR_STATUS, 32'h0, NEVER, 0, 0, 1'b1);
    do_tx(1'b1, 1'b1, FLL_ADDR_INTEG, 32'h5A5A_0002, 0, 1, 0, 1'b1);
    do_tx(1'b1, 1'b1, FLL_ADDR_CFG1, 32'h0000_0003, 1, 0, 0, 1'b1);
    do_tx(1'b1, 1'b1, FLL_ADDR_CFG2, 32'h0000_0004, 0, 2, LOCK_TO - SYNC - 1, 1'b1);
    do_tx(1'b1, 1'b1, FLL_ADDR_CFG2, 32'h0000_0005, 0, 2, LOCK_TO - SYNC, 1'b1);
    do_tx(1'b1, 1'b0, FLL_ADDR_STATUS, 32'h0000_0006, ACK_TO - 1, 0, 0, 1'b1);
    do_tx(1'b1, 1'b0, FLL_ADDR_STATUS, 32'h0000_0007, ACK_TO, 0, 0, 1'b1);
    do_tx(1'b0, 1'b1, FLL_ADDR_STATUS, 32'h0, 0, 1, 0, 1'b1);

    // Reset during REQ: command is lost, no response
    wait_idle();
    do_tx(1'b0, 1'b0, FLL_ADDR_CFG1, 32'h0, NEVER, 0, 0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_fll_req", 32'(bus.fll_req), 32'd0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("midrst_lock_o", 32'(lock_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("ready_after_midrst", 32'(bus.cmd_ready), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        5:       d = ACK_TO - 2;
        6:       d = ACK_TO - 1;
        7:       d = ACK_TO;
        8:       d = NEVER;
        default: d = int'($urandom_range(0, 4));
      endcase
      do_tx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, d, int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 35)),
            1'b1);
    end

    wait_idle();
    repeat (5) @(negedge clk_i);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
